// File: rtl/nibble_serial_add_if.sv
// Handshake/bus bundle for nibble_serial_add_ctrl.
// Optional subtract port appears when NIBBLE_SERIAL_SUB_EN is defined.
interface nibble_serial_add_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done_valid;
  logic             done_ready;

`ifdef NIBBLE_SERIAL_SUB_EN
  // operand source / result consumer side
  modport master (
    output start_valid, a, b, cin, sub, done_ready,
    input  start_ready, sum, cout, ovf, busy, done_valid
  );
  // sequencer side
  modport slave (
    input  start_valid, a, b, cin, sub, done_ready,
    output start_ready, sum, cout, ovf, busy, done_valid
  );
`else
  // operand source / result consumer side
  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, sum, cout, ovf, busy, done_valid
  );
  // sequencer side
  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, sum, cout, ovf, busy, done_valid
  );
`endif
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add performed over WIDTH/4 cycles on one
// 4-bit ripple slice, least-significant nibble first, carry kept in a register.
// Optional feature: define NIBBLE_SERIAL_SUB_EN to add a 'sub' input (a - b).

// One full adder bit of the slice.
module nibble_serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serial_add_if.slave  io
);
  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [IDXW-1:0]     idx;
  logic                carry;
  logic [N-1:0][3:0]   a_q;
  logic [N-1:0][3:0]   b_q;
  logic [N-1:0][3:0]   sum_q;
  logic                cout_q;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;

  logic [3:0]          sl_a;
  logic [3:0]          sl_b;
  logic [3:0]          sl_s;
  logic [4:0]          sl_c;
  logic [N-1:0][3:0]   sum_nxt;
  logic                last;
  logic                accept;
  logic [WIDTH-1:0]    b_load;
  logic                c_load;

  assign io.start_ready = (state == IDLE);
  assign io.sum         = sum_q;
  assign io.cout        = cout_q;
  assign io.ovf         = ovf_q;
  assign io.busy        = busy_q;
  assign io.done_valid  = done_q;

  assign accept = (state == IDLE) && io.start_valid;
  assign last   = (idx == IDXW'(N - 1));

`ifdef NIBBLE_SERIAL_SUB_EN
  // subtract stores ~b with a forced carry-in of 1, so the slice only adds
  assign b_load = io.sub ? ~io.b : io.b;
  assign c_load = io.sub ? 1'b1 : io.cin;
`else
  assign b_load = io.b;
  assign c_load = io.cin;
`endif

  // Operand nibbles for the current step feed the slice.
  assign sl_a    = a_q[idx];
  assign sl_b    = b_q[idx];
  assign sl_c[0] = carry;

  // 4-bit ripple slice: carry chain through an array of full adders.
  nibble_serial_fa u_fa [3:0] (
    .a  (sl_a),
    .b  (sl_b),
    .ci (sl_c[3:0]),
    .s  (sl_s),
    .co (sl_c[4:1])
  );

  // Sum with the current nibble merged in; used for the final overflow check.
  always_comb begin
    sum_nxt      = sum_q;
    sum_nxt[idx] = sl_s;
  end

  // Sequencer: accept, step through nibbles, present result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= io.a;
            b_q    <= b_load;
            carry  <= c_load;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q <= sum_nxt;
          carry <= sl_c[4];
          if (last) begin
            // b_q already holds the effective (possibly inverted) operand
            cout_q <= sl_c[4];
            ovf_q  <= (a_q[N-1][3] == b_q[N-1][3]) &&
                      (sum_nxt[N-1][3] != a_q[N-1][3]);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (io.done_ready) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH = 16).
// Subtract vectors run only when NIBBLE_SERIAL_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  nibble_serial_add_if #(.WIDTH(W)) io ();

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for done_valid; n = edges waited, bc = cycles busy was seen high.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (!io.done_valid && n < 20) begin
      if (io.busy) bc++;
      tick();
      n++;
    end
  endtask

  // One operation; release=1 means done_ready is high and result is taken.
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic [15:0] es, input logic ec,
                    input logic eo, input bit release_res);
    int n, bc;
    io.a = a; io.b = b; io.cin = ci; io.start_valid = 1'b1;
    io.done_ready = release_res;
    tick();
    io.start_valid = 1'b0;
    // operands change after acceptance must not matter
    io.a = ~a; io.b = ~b; io.cin = ~ci;
    chk({tag, ".busy0"}, io.busy, 1);
    chk({tag, ".rdy0"}, io.start_ready, 0);
    wait_done(n, bc);
    chk({tag, ".lat"}, n, 4);
    chk({tag, ".busycnt"}, bc, 4);
    chk({tag, ".sum"}, io.sum, es);
    chk({tag, ".cout"}, io.cout, ec);
    chk({tag, ".ovf"}, io.ovf, eo);
    if (release_res) begin
      tick();
      chk({tag, ".dv_drop"}, io.done_valid, 0);
      chk({tag, ".rdy_back"}, io.start_ready, 1);
      chk({tag, ".sum_hold"}, io.sum, es);
    end
  endtask

  initial begin
    int n, bc;
    logic [15:0] s_hold;
    io.start_valid = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0; io.done_ready = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
    io.sub = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst.ready", io.start_ready, 1);
    chk("rst.dv", io.done_valid, 0);
    chk("rst.busy", io.busy, 0);
    chk("rst.sum", io.sum, 0);
    chk("rst.cout", io.cout, 0);
    chk("rst.ovf", io.ovf, 0);

    op("add1234", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1);
    op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    op("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    op("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
    op("allone",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1);

    // backpressure: hold result, new operands waiting
    op("bp", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    io.a = 16'h1111; io.b = 16'h2222; io.cin = 1'b0; io.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.sum", io.sum, 16'h0100);
      chk("bp.dv", io.done_valid, 1);
      chk("bp.rdy", io.start_ready, 0);
      chk("bp.busy", io.busy, 0);
    end
    io.done_ready = 1'b1;
    tick();
    chk("bp.idle", io.start_ready, 1);
    chk("bp.dv_drop", io.done_valid, 0);
    chk("bp.sum_hold", io.sum, 16'h0100);
    tick();
    io.start_valid = 1'b0;
    chk("bp.accept", io.busy, 1);
    wait_done(n, bc);
    chk("bp.lat", n, 4);
    chk("bp.sum2", io.sum, 16'h3333);
    tick();

    // reset during second RUN cycle aborts the operation
    io.a = 16'hAAAA; io.b = 16'h5555; io.cin = 1'b1; io.start_valid = 1'b1;
    tick();
    io.start_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.sum", io.sum, 0);
    chk("abort.busy", io.busy, 0);
    chk("abort.dv", io.done_valid, 0);
    chk("abort.cout", io.cout, 0);
    chk("abort.rdy", io.start_ready, 1);
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      if (io.done_valid || io.busy) bc++;
      tick();
    end
    chk("abort.quiet", bc, 0);
    op("after", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1);

`ifdef NIBBLE_SERIAL_SUB_EN
    io.sub = 1'b1;
    op("sub57", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1);
    op("sub8k", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1);
    io.sub = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
